// File: rtl/prog_mem.sv
// Program memory for the 4-bit CPU: DEPTH x DATA_W words, synchronous write,
// combinational read, asynchronous clear of every word while rst is high.
module prog_mem #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              we,
  output logic [DATA_W-1:0] out
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset dominates any clock edge seen while it is held, so a write with rst=1 is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[addr] <= data;
    end
  end

  assign out = mem[addr];

endmodule

// File: tb/tb_prog_mem.sv
// Directed-vector bench for prog_mem: reset clear, write enable, read-after-write,
// address independence, full sweep and reset during operation.
module tb_prog_mem;

  logic       clk;
  logic       rst;
  logic [3:0] addr;
  logic [3:0] data;
  logic       we;
  logic [3:0] out;

  int n_checks;
  int n_fail;

  prog_mem #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .addr(addr),
    .data(data),
    .we  (we),
    .out (out)
  );

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic pulse_clk();
    #2 clk = 1'b1;
    #5 clk = 1'b0;
    #3;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [3:0] d);
    addr = a;
    data = d;
    we   = 1'b1;
    pulse_clk();
    we   = 1'b0;
  endtask

  task automatic read_word(input string tag, input logic [3:0] a, input logic [3:0] exp);
    addr = a;
    #1;
    check_eq(tag, out, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clk  = 1'b0;
    rst  = 1'b0;
    addr = 4'd0;
    data = 4'd0;
    we   = 1'b0;
    #1;

    // Reset with no clock activity
    rst = 1'b1;
    #2;
    for (int a = 0; a < 16; a++) begin
      read_word("reset_clear", 4'(a), 4'b0000);
    end
    rst = 1'b0;
    #2;

    // Write disabled
    addr = 4'd0; data = 4'b0000; we = 1'b0;
    pulse_clk();
    check_eq("we0_zero", out, 4'b0000);
    data = 4'b1111;
    pulse_clk();
    check_eq("we0_hold", out, 4'b0000);

    // Basic write: old value before the edge, new value right after it
    addr = 4'd0; data = 4'b0001; we = 1'b1;
    #2;
    check_eq("pre_edge", out, 4'b0000);
    clk = 1'b1;
    #1;
    check_eq("post_edge", out, 4'b0001);
    #4 clk = 1'b0;
    #3;
    we = 1'b0; data = 4'b1110;
    pulse_clk();
    check_eq("we0_keep", out, 4'b0001);

    // Address independence, reads follow addr with no clock
    write_word(4'd3, 4'b1010);
    write_word(4'd12, 4'b0101);
    read_word("addr3", 4'd3, 4'b1010);
    read_word("addr12", 4'd12, 4'b0101);
    read_word("addr0", 4'd0, 4'b0001);
    read_word("addr3_again", 4'd3, 4'b1010);

    // Full sweep with value = addr ^ 1111
    for (int a = 0; a < 16; a++) begin
      write_word(4'(a), 4'(a) ^ 4'b1111);
    end
    for (int a = 0; a < 16; a++) begin
      read_word("sweep", 4'(a), 4'(a) ^ 4'b1111);
    end

    // Reset between edges clears immediately
    addr = 4'd0;
    #1;
    check_eq("prefill0", out, 4'b1111);
    rst = 1'b1;
    #1;
    check_eq("mid_rst0", out, 4'b0000);
    read_word("mid_rst15", 4'd15, 4'b0000);
    read_word("mid_rst9", 4'd9, 4'b0000);

    // Write attempted while reset is held must be dropped
    addr = 4'd7; data = 4'b0111; we = 1'b1;
    pulse_clk();
    we = 1'b0;
    rst = 1'b0;
    #1;
    check_eq("rst_wins", out, 4'b0000);
    read_word("rst_wins_15", 4'd15, 4'b0000);

    // First write after deassertion lands
    write_word(4'd7, 4'b0111);
    read_word("post_rst_write", 4'd7, 4'b0111);
    read_word("post_rst_other", 4'd8, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
- Program memory for the 4-bit CPU: 16 words x 4 bits, addressed by the program counter or loader.
- Synchronous write on the rising clock edge when write enable is high.
- Combinational (asynchronous) read of the addressed word.
- Asynchronous active-high reset clears every word to zero.

Parameters:
- DATA_W, 4, width of each memory word and of the data/out ports.
- ADDR_W, 4, address width.
- DEPTH, 16 (2**ADDR_W), number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all writes occur on its rising edge.
- rst  input  1  asynchronous, active-high reset; clears all words to 0.
- addr  input  ADDR_W  word address for both read and write.
- data  input  DATA_W  write data.
- we  input  1  write enable, sampled on the rising edge of clk.
- out  output  DATA_W  read data; always reflects mem[addr].

Behaviour:
- Storage: array of DEPTH words of DATA_W bits each.
- Reset:
  - While rst=1, all words are forced to 0 immediately, with no clock required.
  - out therefore reads 0 for any addr.
  - Writes are ignored while rst=1.
  - Reset asserted mid-operation discards all contents.
- Write:
  - On a rising clk edge with rst=0 and we=1, mem[addr] <= data.
  - With we=0, memory is unchanged.
  - addr and data are sampled at the edge only; changes between edges have no effect on storage.
- Read:
  - out = mem[addr] combinationally, with zero-cycle latency from an addr change.
  - After a write edge, out reflects the newly written value in the same cycle once the edge has occurred (read-after-write visible immediately).
  - Before the edge, out shows the old value even if we=1 and data differs.
- Width rules:
  - Full address range 0..15 is valid; no wrap or out-of-range case exists.
  - data is stored exactly, with no truncation or extension.
- Simultaneous events:
  - rst=1 at a clk edge with we=1: reset wins and the word stays 0.
  - Deassertion of rst takes effect asynchronously; the first write can occur on the next rising edge with rst=0.
- No handshake, no busy state, no state machine; one write per cycle maximum.
- out never goes X/Z after reset; before the first reset, contents are undefined.

Test Plan:
- Reset: assert rst=1 with no clock, then read addr=0..15 -> out=0000 for every address.
- Write disabled: rst=0, we=0, addr=0000, data=0000, pulse clk -> out=0000; then set data=1111, we=0, pulse clk -> out stays 0000.
- Basic write: addr=0000, we=1, data=0001.
  - Before the rising edge -> out=0000.
  - After the edge -> out=0001.
  - Set we=0 and pulse clk -> out stays 0001.
- Address independence:
  - Write 1010 to addr 3 and 0101 to addr 12.
  - Read addr 3 -> 1010; addr 12 -> 0101; addr 0 -> unchanged.
  - Change addr with no clock edge -> out follows combinationally.
- Full sweep: write value (addr XOR 1111) to all 16 addresses, then read back each -> out matches for every address; boundary addrs 0000 and 1111 included.
- Reset mid-operation:
  - After filling memory, assert rst between edges -> out=0000 immediately.
  - Hold rst=1 with we=1, data=0111 across a rising edge -> word remains 0000 after rst deasserts.
